digest_serializer: RTL and testbench
====================================

Name: digest_serializer

Overview:
Transmit-side counterpart of the input controller. Captures the full-width digest from the BLAKE2 core when digest_valid pulses, then streams it out over a narrow BUS_WIDTH bus with a valid/ready handshake, most-significant word first. Supports truncated output (BLAKE2 variable digest length) via a word-count input sampled at capture. Sits between the hash core's digest output and the external narrow output port.

Parameters:
BUS_WIDTH, 2, output word width in bits (matches controller din width)
DIGEST_WIDTH, 16, digest width from hash core (512 in full BLAKE2b); must be an integer multiple of BUS_WIDTH
OUT_WORDS, DIGEST_WIDTH/BUS_WIDTH, derived maximum number of output words; not overridden
CNT_W, $clog2(OUT_WORDS+1), derived counter width

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
digest_valid  input  1  single-cycle pulse from hash core: digest is valid
digest  input  DIGEST_WIDTH  digest value, sampled only when captured
out_words  input  CNT_W  words to emit, sampled with digest; 0 or >OUT_WORDS means OUT_WORDS
dout  output  BUS_WIDTH  output word
dout_valid  output  1  dout holds a valid word
dout_ready  input  1  downstream accepts the word this cycle
dout_last  output  1  current word is the final word of the digest
busy  output  1  a digest is held or being sent
done  output  1  one-cycle pulse after the final word is transferred
overrun  output  1  one-cycle pulse: digest_valid arrived while busy and was dropped

Behaviour:
- Reset (async, reset_n=0): state=IDLE, shift register=0, remaining=0; dout=0, dout_valid=0, dout_last=0, busy=0, done=0, overrun=0. Reset mid-stream drops the digest with no done pulse.
- States: IDLE, SEND.
- IDLE: busy=0, dout_valid=0, dout=0. On digest_valid=1: capture digest into shift register, remaining = effective count (out_words, clamped per above), go to SEND. dout_valid rises the cycle after the capture edge (latency 1).
- SEND: busy=1, dout_valid=1, dout = shift register[DIGEST_WIDTH-1 -: BUS_WIDTH], dout_last = (remaining==1).
- Transfer = dout_valid & dout_ready at a rising edge. On transfer: shift register shifts left by BUS_WIDTH (zero fill), remaining decrements.
- dout, dout_last held stable while dout_valid=1 and dout_ready=0; no combinational path from dout_ready to dout_valid.
- Transfer with dout_last=1: go to IDLE; done=1 for exactly the following cycle (same cycle dout_valid=0, busy=0).
- With dout_ready held high, N words go out on N consecutive cycles.
- digest_valid while in SEND (including the cycle of the final transfer): digest ignored, shift register and count untouched, overrun=1 for the next cycle. digest_valid in the cycle done is high (state IDLE): accepted normally.
- Truncation: only the top out_words*BUS_WIDTH bits are sent; remaining low bits discarded.
- dout_ready while IDLE has no effect.

Test Plan:
- Reset mid-stream: drive reset_n=0 after 3 of 8 words -> all outputs 0 asynchronously; after release digest_valid with 16'h1234 sends full 8 words 0,1,0,2,0,3,1,0.
- Full digest, ready high: digest=16'hB4E1, out_words=0 -> dout_valid from cycle after capture, 8 consecutive words 2,3,1,0,3,2,0,1; dout_last only on word 8; done pulse the next cycle; busy high exactly 8 cycles.
- Backpressure: same digest, dout_ready toggled 1,0,0,1,... -> identical word sequence, dout/dout_last stable during every stall, no word repeated or skipped.
- Truncation: digest=16'hB4E1, out_words=3 -> words 2,3,1 only, dout_last on word 3, done follows; out_words=9 -> treated as 8.
- Overrun: second digest_valid (16'hFFFF) during word 4 of first digest, and another coincident with the final transfer -> both dropped, overrun pulses once each, first digest output unchanged.
- Back-to-back: digest_valid in the done cycle with 16'h8000 -> accepted; words 2,0,0,0,0,0,0,0 follow with no overrun.

Source files
------------

// File: rtl/digest_serializer.sv
// Captures a hash digest and streams it out MSW-first over a narrow
// valid/ready bus, with optional truncation to a requested word count.
module digest_serializer #(
  parameter  int BUS_WIDTH    = 2,
  parameter  int DIGEST_WIDTH = 16,
  localparam int OUT_WORDS    = DIGEST_WIDTH / BUS_WIDTH,
  localparam int CNT_W        = $clog2(OUT_WORDS + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    digest_valid,
  input  logic [DIGEST_WIDTH-1:0] digest,
  input  logic [CNT_W-1:0]        out_words,
  output logic [BUS_WIDTH-1:0]    dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_last,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(OUT_WORDS);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t                  r_state;
  state_t                  w_next;
  logic [DIGEST_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]        r_remaining;
  logic                    r_done;
  logic                    r_overrun;

  logic                    w_capture;
  logic                    w_xfer;
  logic                    w_last;
  logic [CNT_W-1:0]        w_eff_cnt;

  assign w_last    = (r_state == SEND) && (r_remaining == ONE);
  assign w_xfer    = (r_state == SEND) && dout_ready;
  assign w_capture = (r_state == IDLE) && digest_valid;

  // Zero or out-of-range counts mean "send the whole digest".
  assign w_eff_cnt = ((out_words == '0) || (out_words > MAX_CNT))
                   ? MAX_CNT : out_words;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (digest_valid)    w_next = SEND;
      SEND: if (w_xfer && w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    dout_valid = 1'b0;
    busy       = 1'b0;
    dout       = '0;
    dout_last  = 1'b0;
    if (r_state == SEND) begin
      dout_valid = 1'b1;
      busy       = 1'b1;
      dout       = r_shift[DIGEST_WIDTH-1 -: BUS_WIDTH];
      dout_last  = w_last;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift     <= '0;
      r_remaining <= '0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_done    <= w_xfer && w_last;
      r_overrun <= digest_valid && (r_state == SEND);
      if (w_capture) begin
        r_shift     <= digest;
        r_remaining <= w_eff_cnt;
      end else if (w_xfer) begin
        r_shift     <= r_shift << BUS_WIDTH;
        r_remaining <= r_remaining - ONE;
      end
    end
  end

  assign done    = r_done;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_digest_serializer.sv
// Self-checking bench for digest_serializer: directed scenarios plus
// random traffic compared against a word-queue reference model.
module tb_digest_serializer;

  localparam int BW    = 2;
  localparam int DW    = 16;
  localparam int NW    = DW / BW;
  localparam int CNT_W = $clog2(NW + 1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          digest_valid;
  logic [DW-1:0] digest;
  logic [CNT_W-1:0] out_words;
  logic [BW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_last;
  logic          busy;
  logic          done;
  logic          overrun;

  digest_serializer #(
    .BUS_WIDTH   (BW),
    .DIGEST_WIDTH(DW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .digest_valid(digest_valid),
    .digest      (digest),
    .out_words   (out_words),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_last   (dout_last),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  int q[$];
  bit m_done;
  bit m_ovr;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_outputs();
    int v;
    v = (q.size() > 0) ? 1 : 0;
    chk("dout_valid", 32'(dout_valid), 32'(v));
    chk("busy",       32'(busy),       32'(v));
    chk("dout",       32'(dout),       v ? 32'(q[0]) : 32'd0);
    chk("dout_last",  32'(dout_last),  32'(q.size() == 1));
    chk("done",       32'(done),       32'(m_done));
    chk("overrun",    32'(overrun),    32'(m_ovr));
  endtask

  // One clock cycle: drive inputs, advance the model, compare after the edge.
  task automatic step(input bit dv, input logic [DW-1:0] dg,
                      input int ow, input bit rdy);
    bit xfer;
    bit was_busy;
    int eff;
    digest_valid = dv;
    digest       = dg;
    out_words    = CNT_W'(ow);
    dout_ready   = rdy;
    was_busy = q.size() > 0;
    xfer     = was_busy && rdy;
    m_done   = xfer && (q.size() == 1);
    m_ovr    = dv && was_busy;
    if (xfer) void'(q.pop_front());
    if (dv && !was_busy) begin
      eff = (ow == 0 || ow > NW) ? NW : ow;
      for (int k = 0; k < eff; k++)
        q.push_back(int'((dg >> (DW - BW * (k + 1))) & ((1 << BW) - 1)));
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 0, 1'b1);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    q.delete();
    m_done = 1'b0;
    m_ovr  = 1'b0;
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_dout",  32'(dout),       32'd0);
    chk("rst_last",  32'(dout_last),  32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_done",  32'(done),       32'd0);
    chk("rst_ovr",   32'(overrun),    32'd0);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    digest_valid = 1'b0;
    digest       = '0;
    out_words    = '0;
    dout_ready   = 1'b0;
    reset_n      = 1'b1;
    #2;
    apply_reset();
    idle(2);

    // Full digest, ready high
    step(1'b1, 16'hB4E1, 0, 1'b1);
    idle(10);

    // Backpressure pattern 1,0,0,1,...
    step(1'b1, 16'hB4E1, 0, 1'b0);
    for (int i = 0; i < 24; i++) step(1'b0, '0, 0, (i % 3) == 0);
    idle(3);

    // Truncation to 3 words, then count 9 treated as 8
    step(1'b1, 16'hB4E1, 3, 1'b1);
    idle(5);
    step(1'b1, 16'hB4E1, 9, 1'b1);
    idle(10);

    // Overrun during word 4 and coincident with final transfer
    step(1'b1, 16'hB4E1, 0, 1'b1);
    step(1'b0, '0, 0, 1'b1);
    step(1'b0, '0, 0, 1'b1);
    step(1'b0, '0, 0, 1'b1);
    step(1'b1, 16'hFFFF, 0, 1'b1);
    step(1'b0, '0, 0, 1'b1);
    step(1'b0, '0, 0, 1'b1);
    step(1'b0, '0, 0, 1'b1);
    step(1'b1, 16'hFFFF, 0, 1'b1);
    // Back-to-back: accept in the done cycle
    step(1'b1, 16'h8000, 0, 1'b1);
    idle(10);

    // Reset mid-stream after 3 words, then a clean digest
    step(1'b1, 16'hB4E1, 0, 1'b1);
    idle(3);
    apply_reset();
    step(1'b1, 16'h1234, 0, 1'b1);
    idle(10);

    // Random traffic
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 5) == 0, DW'($urandom),
           $urandom_range(0, (1 << CNT_W) - 1),
           $urandom_range(0, 9) < 7);
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
